// File: rtl/alib_coord_conv_arbiter_if.sv
// Requester, response and converter signals of the coordinate-converter arbiter.
// slave = arbiter side, master = requesters/converter side.
interface alib_coord_conv_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]    i_req_valid;
    logic [N_REQ-1:0]    o_req_ready;
    logic [16*N_REQ-1:0] i_req_coord_1;
    logic [16*N_REQ-1:0] i_req_coord_2;
    logic [16*N_REQ-1:0] i_req_coord_3;
    logic [N_REQ-1:0]    o_rsp_valid;
    logic [N_REQ-1:0]    i_rsp_ready;
    logic [15:0]         o_rsp_coord_1;
    logic [15:0]         o_rsp_coord_2;
    logic [15:0]         o_rsp_coord_3;
    logic [15:0]         o_conv_coord_1;
    logic [15:0]         o_conv_coord_2;
    logic [15:0]         o_conv_coord_3;
    logic [15:0]         i_conv_coord_1;
    logic [15:0]         i_conv_coord_2;
    logic [15:0]         i_conv_coord_3;
    logic                o_busy;

    modport slave (
        input  i_req_valid, i_req_coord_1, i_req_coord_2, i_req_coord_3, i_rsp_ready,
               i_conv_coord_1, i_conv_coord_2, i_conv_coord_3,
        output o_req_ready, o_rsp_valid, o_rsp_coord_1, o_rsp_coord_2, o_rsp_coord_3,
               o_conv_coord_1, o_conv_coord_2, o_conv_coord_3, o_busy
    );

    modport master (
        output i_req_valid, i_req_coord_1, i_req_coord_2, i_req_coord_3, i_rsp_ready,
               i_conv_coord_1, i_conv_coord_2, i_conv_coord_3,
        input  o_req_ready, o_rsp_valid, o_rsp_coord_1, o_rsp_coord_2, o_rsp_coord_3,
               o_conv_coord_1, o_conv_coord_2, o_conv_coord_3, o_busy
    );
endinterface

// File: rtl/alib_coord_conv_arbiter.sv
// Round-robin sharing of one combinational coordinate converter among N_REQ streams,
// one transaction in flight. Define ALIB_CCARB_STATS_EN for per-requester grant counters.
module alib_coord_conv_arbiter #(
    parameter int N_REQ        = 2,
    parameter int CONV_LATENCY = 2
) (
    input  logic                      i_SYSTEM_clk,
    input  logic                      i_SYSTEM_rst,
    alib_coord_conv_arbiter_if.slave  bus
`ifdef ALIB_CCARB_STATS_EN
    ,
    output logic [16*N_REQ-1:0]       o_grant_count
`endif
);
    localparam int PW = (N_REQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    typedef struct packed {
        logic [15:0] c1;
        logic [15:0] c2;
        logic [15:0] c3;
    } coord_t;

    state_e          state_q;
    logic [PW-1:0]   ptr_q, gnt_q;
    logic [3:0]      cnt_q;
    coord_t          op_q, res_q;
    logic [N_REQ-1:0] rsp_valid_q;

    logic            found_d;
    logic [PW-1:0]   gnt_d, idx;
    coord_t          req_d;
    logic            accept;

    // Scan downward so the requester closest to ptr_q is written last and wins.
    always_comb begin
        found_d = 1'b0;
        gnt_d   = '0;
        idx     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr_q) + i) % N_REQ);
            if (bus.i_req_valid[idx]) begin
                found_d = 1'b1;
                gnt_d   = idx;
            end
        end
    end

    always_comb begin
        req_d.c1 = bus.i_req_coord_1[16*int'(gnt_d) +: 16];
        req_d.c2 = bus.i_req_coord_2[16*int'(gnt_d) +: 16];
        req_d.c3 = bus.i_req_coord_3[16*int'(gnt_d) +: 16];
    end

    // Reset gates ready so no handshake is advertised while the block is held.
    assign accept          = (state_q == IDLE) && found_d && i_SYSTEM_rst;
    assign bus.o_req_ready = accept ? (N_REQ'(1) << gnt_d) : '0;

    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
        if (!i_SYSTEM_rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
            res_q       <= '0;
            rsp_valid_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= req_d;
                        gnt_q   <= gnt_d;
                        cnt_q   <= 4'(CONV_LATENCY);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        res_q       <= '{c1: bus.i_conv_coord_1, c2: bus.i_conv_coord_2,
                                         c3: bus.i_conv_coord_3};
                        rsp_valid_q <= N_REQ'(1) << gnt_q;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.i_rsp_ready[gnt_q]) begin
                        rsp_valid_q <= '0;
                        ptr_q       <= (gnt_q == PW'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_rsp_valid    = rsp_valid_q;
    assign bus.o_rsp_coord_1  = res_q.c1;
    assign bus.o_rsp_coord_2  = res_q.c2;
    assign bus.o_rsp_coord_3  = res_q.c3;
    assign bus.o_conv_coord_1 = op_q.c1;
    assign bus.o_conv_coord_2 = op_q.c2;
    assign bus.o_conv_coord_3 = op_q.c3;
    assign bus.o_busy         = (state_q != IDLE);

`ifdef ALIB_CCARB_STATS_EN
    logic [N_REQ-1:0][15:0] gcnt_q;

    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
        if (!i_SYSTEM_rst) begin
            gcnt_q <= '0;
        end else if (accept && gcnt_q[gnt_d] != 16'hFFFF) begin
            gcnt_q[gnt_d] <= gcnt_q[gnt_d] + 16'd1;
        end
    end

    assign o_grant_count = gcnt_q;
`endif
endmodule

// File: tb/tb_alib_coord_conv_arbiter.sv
// Directed bench for alib_coord_conv_arbiter: two instances (N_REQ=2/LAT=2, N_REQ=4/LAT=3)
// checked every cycle against a transaction-level model, plus hand-computed expectations.
module tb_alib_coord_conv_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    logic [3:0]  req_valid [2];
    logic [3:0]  rsp_ready [2];
    logic [15:0] coord     [2][4][3];

    alib_coord_conv_arbiter_if #(.N_REQ(2)) b2 ();
    alib_coord_conv_arbiter_if #(.N_REQ(4)) b4 ();

    assign b2.i_req_valid   = req_valid[0][1:0];
    assign b2.i_rsp_ready   = rsp_ready[0][1:0];
    assign b2.i_req_coord_1 = {coord[0][1][0], coord[0][0][0]};
    assign b2.i_req_coord_2 = {coord[0][1][1], coord[0][0][1]};
    assign b2.i_req_coord_3 = {coord[0][1][2], coord[0][0][2]};
    assign b4.i_req_valid   = req_valid[1];
    assign b4.i_rsp_ready   = rsp_ready[1];
    assign b4.i_req_coord_1 = {coord[1][3][0], coord[1][2][0], coord[1][1][0], coord[1][0][0]};
    assign b4.i_req_coord_2 = {coord[1][3][1], coord[1][2][1], coord[1][1][1], coord[1][0][1]};
    assign b4.i_req_coord_3 = {coord[1][3][2], coord[1][2][2], coord[1][1][2], coord[1][0][2]};

    // Converter stub: (c1+1, c2+2, c3+3)
    assign b2.i_conv_coord_1 = b2.o_conv_coord_1 + 16'd1;
    assign b2.i_conv_coord_2 = b2.o_conv_coord_2 + 16'd2;
    assign b2.i_conv_coord_3 = b2.o_conv_coord_3 + 16'd3;
    assign b4.i_conv_coord_1 = b4.o_conv_coord_1 + 16'd1;
    assign b4.i_conv_coord_2 = b4.o_conv_coord_2 + 16'd2;
    assign b4.i_conv_coord_3 = b4.o_conv_coord_3 + 16'd3;

`ifdef ALIB_CCARB_STATS_EN
    logic [31:0] gc2;
    logic [63:0] gc4;
`endif

    alib_coord_conv_arbiter #(.N_REQ(2), .CONV_LATENCY(2)) u2 (
        .i_SYSTEM_clk(clk), .i_SYSTEM_rst(rst), .bus(b2.slave)
`ifdef ALIB_CCARB_STATS_EN
        , .o_grant_count(gc2)
`endif
    );

    alib_coord_conv_arbiter #(.N_REQ(4), .CONV_LATENCY(3)) u4 (
        .i_SYSTEM_clk(clk), .i_SYSTEM_rst(rst), .bus(b4.slave)
`ifdef ALIB_CCARB_STATS_EN
        , .o_grant_count(gc4)
`endif
    );

    function automatic int nreq(input int d); return (d == 0) ? 2 : 4; endfunction
    function automatic int lat(input int d);  return (d == 0) ? 2 : 3; endfunction

    function automatic logic [3:0] o_rdy(input int d);
        return (d == 0) ? {2'b00, b2.o_req_ready} : b4.o_req_ready;
    endfunction
    function automatic logic [3:0] o_rv(input int d);
        return (d == 0) ? {2'b00, b2.o_rsp_valid} : b4.o_rsp_valid;
    endfunction
    function automatic logic o_bsy(input int d);
        return (d == 0) ? b2.o_busy : b4.o_busy;
    endfunction
    function automatic logic [15:0] o_rsp(input int d, input int j);
        if (d == 0) return (j == 0) ? b2.o_rsp_coord_1 : (j == 1) ? b2.o_rsp_coord_2 : b2.o_rsp_coord_3;
        return (j == 0) ? b4.o_rsp_coord_1 : (j == 1) ? b4.o_rsp_coord_2 : b4.o_rsp_coord_3;
    endfunction
    function automatic logic [15:0] o_cnv(input int d, input int j);
        if (d == 0) return (j == 0) ? b2.o_conv_coord_1 : (j == 1) ? b2.o_conv_coord_2 : b2.o_conv_coord_3;
        return (j == 0) ? b4.o_conv_coord_1 : (j == 1) ? b4.o_conv_coord_2 : b4.o_conv_coord_3;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Transaction-level model: a transaction is (owner, operands, age since accept).
    bit          m_busy [2];
    int          m_g    [2];
    int          m_age  [2];
    int          m_rr   [2];
    logic [15:0] m_op   [2][3];
    logic [15:0] m_res  [2][3];
    logic [15:0] m_cnt  [2][4];

    function automatic int mgrant(input int d);
        for (int i = 0; i < nreq(d); i++)
            if (req_valid[d][(m_rr[d] + i) % nreq(d)]) return (m_rr[d] + i) % nreq(d);
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d] <= 1'b0; m_g[d] <= 0; m_age[d] <= 0; m_rr[d] <= 0;
                for (int j = 0; j < 3; j++) begin m_op[d][j] <= '0; m_res[d][j] <= '0; end
                for (int k = 0; k < 4; k++) m_cnt[d][k] <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!m_busy[d]) begin
                    if (mgrant(d) >= 0) begin
                        m_busy[d] <= 1'b1;
                        m_g[d]    <= mgrant(d);
                        m_age[d]  <= 0;
                        for (int j = 0; j < 3; j++) m_op[d][j] <= coord[d][mgrant(d)][j];
                        if (m_cnt[d][mgrant(d)] != 16'hFFFF)
                            m_cnt[d][mgrant(d)] <= m_cnt[d][mgrant(d)] + 16'd1;
                    end
                end else if (m_age[d] < lat(d)) begin
                    m_age[d] <= m_age[d] + 1;
                    if (m_age[d] + 1 == lat(d))
                        for (int j = 0; j < 3; j++) m_res[d][j] <= m_op[d][j] + 16'(j + 1);
                end else if (rsp_ready[d][m_g[d]]) begin
                    m_busy[d] <= 1'b0;
                    m_rr[d]   <= (m_g[d] + 1) % nreq(d);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst && cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                logic [3:0] er, ev;
                er = (!m_busy[d] && mgrant(d) >= 0) ? (4'b0001 << mgrant(d)) : 4'b0000;
                ev = (m_busy[d] && m_age[d] >= lat(d)) ? (4'b0001 << m_g[d]) : 4'b0000;
                chk($sformatf("m%0d req_ready", d), 64'(o_rdy(d)), 64'(er));
                chk($sformatf("m%0d rsp_valid", d), 64'(o_rv(d)), 64'(ev));
                chk($sformatf("m%0d busy", d), 64'(o_bsy(d)), 64'(m_busy[d]));
                for (int j = 0; j < 3; j++) begin
                    chk($sformatf("m%0d conv%0d", d, j), 64'(o_cnv(d, j)), 64'(m_op[d][j]));
                    chk($sformatf("m%0d rsp%0d", d, j), 64'(o_rsp(d, j)), 64'(m_res[d][j]));
                end
`ifdef ALIB_CCARB_STATS_EN
                for (int k = 0; k < nreq(d); k++)
                    chk($sformatf("m%0d gcnt%0d", d, k),
                        64'((d == 0) ? gc2[16*k +: 16] : gc4[16*k +: 16]), 64'(m_cnt[d][k]));
`endif
            end
        end
    end

    task automatic tick(); @(posedge clk); #1; endtask

    task automatic set_c(input int d, input int k, input int a, input int b, input int c);
        coord[d][k][0] = 16'(a); coord[d][k][1] = 16'(b); coord[d][k][2] = 16'(c);
    endtask

    task automatic do_reset();
        for (int d = 0; d < 2; d++) begin req_valid[d] = '0; rsp_ready[d] = '0; end
        #2 rst = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic wait_rsp(input int d, input int k, input string name);
        bit ok = 1'b0;
        logic [3:0] v;
        for (int i = 0; i < 30; i++) begin
            v = o_rv(d);
            if (v[k]) begin ok = 1'b1; break; end
            tick();
        end
        chk({name, " rsp arrives"}, 64'(ok), 64'(1));
    endtask

    task automatic wait_idle(input int d, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!o_bsy(d)) begin ok = 1'b1; break; end
            tick();
        end
        chk({name, " back to idle"}, 64'(ok), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gseq [4];
        int rseq [4];
        int rc1  [4];
        int ng, nr;
        logic [3:0] v;

        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++) set_c(d, k, 0, 0, 0);
        do_reset();

        // Reset state
        for (int d = 0; d < 2; d++) begin
            chk("reset ready", 64'(o_rdy(d)), 64'(0));
            chk("reset rsp_valid", 64'(o_rv(d)), 64'(0));
            chk("reset busy", 64'(o_bsy(d)), 64'(0));
            chk("reset conv1", 64'(o_cnv(d, 0)), 64'(0));
            chk("reset rsp1", 64'(o_rsp(d, 0)), 64'(0));
        end
        cmp_en = 1'b1;

        // Single request, latency 2
        set_c(0, 0, 100, 200, 300);
        rsp_ready[0] = 4'b0011;
        req_valid[0] = 4'b0001;
        #1 chk("single ready", 64'(o_rdy(0)), 64'(1));
        tick();
        req_valid[0] = 4'b0000;
        chk("single busy@T", 64'(o_bsy(0)), 64'(1));
        chk("single conv1@T", 64'(o_cnv(0, 0)), 64'(100));
        chk("single conv3@T", 64'(o_cnv(0, 2)), 64'(300));
        tick();
        chk("single rsp_valid@T+1", 64'(o_rv(0)), 64'(0));
        tick();
        chk("single rsp_valid@T+2", 64'(o_rv(0)), 64'(1));
        chk("single rsp1", 64'(o_rsp(0, 0)), 64'(101));
        chk("single rsp2", 64'(o_rsp(0, 1)), 64'(202));
        chk("single rsp3", 64'(o_rsp(0, 2)), 64'(303));
        tick();
        chk("single busy@T+3", 64'(o_bsy(0)), 64'(0));

        // Contention: grants must alternate 0,1,0,1
        do_reset();
        set_c(0, 0, 10, 10, 10);
        set_c(0, 1, 20, 20, 20);
        rsp_ready[0] = 4'b0011;
        req_valid[0] = 4'b0011;
        #1;
        ng = 0; nr = 0;
        for (int i = 0; i < 40 && nr < 4; i++) begin
            v = o_rdy(0);
            if (v != 0 && ng < 4) begin gseq[ng] = (v == 4'b0010) ? 1 : 0; ng++; end
            v = o_rv(0);
            if (v != 0 && nr < 4) begin
                rseq[nr] = (v == 4'b0010) ? 1 : 0;
                rc1[nr]  = int'(o_rsp(0, 0));
                nr++;
            end
            tick();
        end
        req_valid[0] = 4'b0000;
        chk("contend grants seen", 64'(ng), 64'(4));
        chk("contend rsps seen", 64'(nr), 64'(4));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("contend grant%0d", i), 64'(gseq[i]), 64'(i % 2));
            chk($sformatf("contend rsp owner%0d", i), 64'(rseq[i]), 64'(i % 2));
            chk($sformatf("contend rsp1_%0d", i), 64'(rc1[i]), 64'((i % 2 == 1) ? 21 : 11));
        end
        wait_idle(0, "contend");

        // Backpressure on requester 0; requester 1's ready must be ignored
        do_reset();
        set_c(0, 0, 5, 6, 7);
        rsp_ready[0] = 4'b0010;
        req_valid[0] = 4'b0001;
        wait_rsp(0, 0, "bp");
        for (int i = 0; i < 5; i++) begin
            chk("bp rsp_valid held", 64'(o_rv(0)), 64'(1));
            chk("bp rsp1 held", 64'(o_rsp(0, 0)), 64'(6));
            chk("bp rsp3 held", 64'(o_rsp(0, 2)), 64'(10));
            chk("bp req_ready low", 64'(o_rdy(0)), 64'(0));
            tick();
        end
        req_valid[0] = 4'b0000;
        rsp_ready[0] = 4'b0011;
        tick();
        chk("bp busy after hs", 64'(o_bsy(0)), 64'(0));
        chk("bp rsp_valid after hs", 64'(o_rv(0)), 64'(0));

        // Wrap with four requesters
        do_reset();
        set_c(1, 3, 3000, 3001, 3002);
        set_c(1, 0, 7, 8, 9);
        rsp_ready[1] = 4'b1111;
        req_valid[1] = 4'b1000;
        #1 chk("wrap grant3", 64'(o_rdy(1)), 64'(4'b1000));
        tick();
        req_valid[1] = 4'b0001;
        wait_rsp(1, 3, "wrap r3");
        chk("wrap r3 rsp1", 64'(o_rsp(1, 0)), 64'(3001));
        tick();
        chk("wrap grant0 after wrap", 64'(o_rdy(1)), 64'(4'b0001));
        wait_rsp(1, 0, "wrap r0");
        chk("wrap r0 rsp1", 64'(o_rsp(1, 0)), 64'(8));
        tick();
        req_valid[1] = 4'b1001;
        #1 chk("wrap ptr at 1", 64'(o_rdy(1)), 64'(4'b1000));
        tick();
        req_valid[1] = 4'b0000;
        wait_idle(1, "wrap");

        // Reset in the middle of WAIT
        do_reset();
        set_c(0, 1, 40, 41, 42);
        rsp_ready[0] = 4'b0011;
        req_valid[0] = 4'b0010;
        tick();
        req_valid[0] = 4'b0000;
        chk("midrst busy before", 64'(o_bsy(0)), 64'(1));
        #3 rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("midrst ready", 64'(o_rdy(d)), 64'(0));
            chk("midrst rsp_valid", 64'(o_rv(d)), 64'(0));
            chk("midrst busy", 64'(o_bsy(d)), 64'(0));
            chk("midrst conv1", 64'(o_cnv(d, 0)), 64'(0));
            chk("midrst rsp1", 64'(o_rsp(d, 0)), 64'(0));
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("midrst no stale rsp", 64'(o_rv(0)), 64'(0));
            tick();
        end
        set_c(0, 1, 50, 51, 52);
        req_valid[0] = 4'b0010;
        #1 chk("midrst grant1", 64'(o_rdy(0)), 64'(4'b0010));
        tick();
        req_valid[0] = 4'b0000;
        wait_rsp(0, 1, "midrst r1");
        chk("midrst rsp1", 64'(o_rsp(0, 0)), 64'(51));
        chk("midrst rsp2", 64'(o_rsp(0, 1)), 64'(53));
        chk("midrst rsp3", 64'(o_rsp(0, 2)), 64'(55));
        wait_idle(0, "midrst");

`ifdef ALIB_CCARB_STATS_EN
        do_reset();
        rsp_ready[0] = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            req_valid[0] = (i < 3) ? 4'b0001 : 4'b0010;
            tick();
            req_valid[0] = 4'b0000;
            wait_idle(0, "stats");
            tick();
        end
        chk("stats gcnt0", 64'(gc2[15:0]), 64'(3));
        chk("stats gcnt1", 64'(gc2[31:16]), 64'(1));
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
